// File: rtl/alu_pkg.sv
// Shared definitions for the RV32 integer ALU and its pipelined execution wrapper.
package alu_pkg;

  localparam int ALU_SEL_W     = 4;
  localparam int DEFAULT_WIDTH = 32;

  localparam logic [ALU_SEL_W-1:0] ALU_ADD  = 4'b0000;
  localparam logic [ALU_SEL_W-1:0] ALU_SUB  = 4'b1000;
  localparam logic [ALU_SEL_W-1:0] ALU_SLL  = 4'b0001;
  localparam logic [ALU_SEL_W-1:0] ALU_SLT  = 4'b0010;
  localparam logic [ALU_SEL_W-1:0] ALU_SLTU = 4'b0011;
  localparam logic [ALU_SEL_W-1:0] ALU_XOR  = 4'b0100;
  localparam logic [ALU_SEL_W-1:0] ALU_SRL  = 4'b0101;
  localparam logic [ALU_SEL_W-1:0] ALU_SRA  = 4'b1101;
  localparam logic [ALU_SEL_W-1:0] ALU_OR   = 4'b0110;
  localparam logic [ALU_SEL_W-1:0] ALU_AND  = 4'b0111;

endpackage

// File: rtl/alu.sv
// Combinational RV32 integer ALU; unassigned select codes produce zero.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic [ALU_SEL_W-1:0] alu_select,
  output logic [WIDTH-1:0]     result
);

  logic [4:0] shamt;
  logic       lt_signed;
  logic       lt_unsigned;

  assign shamt       = in_b[4:0];
  assign lt_signed   = $signed(in_a) < $signed(in_b);
  assign lt_unsigned = in_a < in_b;

  always_comb begin
    result = '0;
    case (alu_select)
      ALU_ADD:  result = in_a + in_b;
      ALU_SUB:  result = in_a - in_b;
      ALU_SLL:  result = in_a << shamt;
      ALU_SLT:  result = {{(WIDTH-1){1'b0}}, lt_signed};
      ALU_SLTU: result = {{(WIDTH-1){1'b0}}, lt_unsigned};
      ALU_XOR:  result = in_a ^ in_b;
      ALU_SRL:  result = in_a >> shamt;
      ALU_SRA:  result = $signed(in_a) >>> shamt;
      ALU_OR:   result = in_a | in_b;
      ALU_AND:  result = in_a & in_b;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Two-stage valid/ready wrapper around the ALU: S1 holds the request, S2 holds
// the tagged result. Full backpressure, in order, one operation per cycle.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic [ALU_SEL_W-1:0] alu_select,
  input  logic [TAG_W-1:0]     req_tag,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [WIDTH-1:0]     result,
  output logic [TAG_W-1:0]     resp_tag,
  output logic                 resp_zero,
  output logic [31:0]          ops_done
);

  // Handshake: a beat transfers on any rising edge where valid && ready.
  // A producer holds valid and payload steady until ready; ready may depend
  // combinationally on resp_ready (req_ready looks through both stages).
  logic                 s1_valid;
  logic                 s2_valid;
  logic                 s1_load;
  logic                 s2_load;
  logic                 req_fire;
  logic                 resp_fire;
  logic [WIDTH-1:0]     s1_a;
  logic [WIDTH-1:0]     s1_b;
  logic [ALU_SEL_W-1:0] s1_sel;
  logic [TAG_W-1:0]     s1_tag;
  logic [WIDTH-1:0]     alu_result;
  logic [WIDTH-1:0]     s2_result;
  logic [TAG_W-1:0]     s2_tag;
  logic                 s2_zero;
  logic [31:0]          ops_done_q;

  assign s2_load   = !s2_valid || resp_ready;
  assign s1_load   = !s1_valid || s2_load;
  assign req_ready = !rst && s1_load;
  assign req_fire  = req_valid && req_ready;
  assign resp_fire = s2_valid && resp_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_sel   <= '0;
      s1_tag   <= '0;
    end else if (s1_load) begin
      s1_valid <= req_fire;
      if (req_fire) begin
        s1_a   <= in_a;
        s1_b   <= in_b;
        s1_sel <= alu_select;
        s1_tag <= req_tag;
      end
    end
  end

  alu #(.WIDTH(WIDTH)) u_alu (
    .in_a       (s1_a),
    .in_b       (s1_b),
    .alu_select (s1_sel),
    .result     (alu_result)
  );

  // S2 payload only changes when a new operation arrives, so a drained
  // stage keeps its last values visible with resp_valid low.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid  <= 1'b0;
      s2_result <= '0;
      s2_tag    <= '0;
      s2_zero   <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_result <= alu_result;
        s2_tag    <= s1_tag;
        s2_zero   <= (alu_result == '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ops_done_q <= '0;
    end else if (resp_fire) begin
      ops_done_q <= ops_done_q + 32'd1;
    end
  end

  assign resp_valid = s2_valid;
  assign result     = s2_result;
  assign resp_tag   = s2_tag;
  assign resp_zero  = s2_zero;
  assign ops_done   = ops_done_q;

endmodule
